// File: rtl/crossing_pkg.sv
// ---------------------------------------------------------------------------
// crossing_pkg
// Shared types and constants for the river-crossing scheduler.
//   state_t      : scheduler states (IDLE, MOVE, LAND)
//   GRANT_*      : job codes carried on the grant output
//   CANOE_LAST_DEFAULT : far-bank value of the canoe track counter
//   BCD_MAX      : largest value of one BCD digit
//   priority_winner() : fixed-priority pick among simultaneous requests
// ---------------------------------------------------------------------------
package crossing_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        LAND = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_CAT   = 2'd0;
    localparam logic [1:0] GRANT_DOG   = 2'd1;
    localparam logic [1:0] GRANT_MOUSE = 2'd2;
    localparam logic [1:0] GRANT_CANOE = 2'd3;

    localparam int CANOE_LAST_DEFAULT = 15;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Cat beats dog beats mouse; if none of those asked, the job is a
    // canoe-only crossing (only meaningful when some request is present).
    function automatic logic [1:0] priority_winner(input logic cat,
                                                   input logic dog,
                                                   input logic mouse);
        if (cat)
            return GRANT_CAT;
        else if (dog)
            return GRANT_DOG;
        else if (mouse)
            return GRANT_MOUSE;
        else
            return GRANT_CANOE;
    endfunction

endpackage

// File: rtl/bcd_move_counter.sv
// ---------------------------------------------------------------------------
// bcd_move_counter
// Two-digit BCD counter of completed crossings. Counts up by one on each
// cycle with inc high and sticks at 99.
// Ports:
//   clk   in  1  clock
//   rst   in  1  asynchronous active-high reset (clears to 00)
//   inc   in  1  add one this cycle
//   ones  out 4  BCD units digit
//   tens  out 4  BCD tens digit
// ---------------------------------------------------------------------------
module bcd_move_counter
    import crossing_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [3:0] ones,
    output logic [3:0] tens
);

    logic saturated;

    assign saturated = (ones == BCD_MAX) && (tens == BCD_MAX);

    // Units roll over 9 -> 0 and carry into tens; once both digits read 9
    // further increments are ignored so the display never wraps to 00.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones <= 4'd0;
            tens <= 4'd0;
        end else if (inc && !saturated) begin
            if (ones == BCD_MAX) begin
                ones <= 4'd0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/crossing_scheduler.sv
// ---------------------------------------------------------------------------
// crossing_scheduler
// Sequences each river crossing of the cat/dog/mouse game: arbitrates the
// request pulses, checks legality, walks the canoe along its track at a
// divided movement tick, then flips bank positions and counts the move.
// Optional build macro: SAFETY_CHECK_EN -- when defined, a move that would
// leave the cat alone with the dog or the mouse on the departing bank is
// rejected as well.
// Parameters:
//   TICK_DIV    clk_1kHz cycles per movement tick
//   CANOE_LAST  far-bank value of cnt_canoe (ticks per transit)
// Ports:
//   clk_1kHz        in  1  system clock
//   btn_0_out       in  1  asynchronous active-high reset
//   en              in  1  play enabled, gates acceptance of requests
//   req_cat/dog/mouse/canoe in 1 each  single-cycle request pulses
//   busy            out 1  transit in progress (MOVE or LAND)
//   grant           out 2  active job code, held while idle
//   req_drop        out 1  pulse: a request was rejected
//   step_pulse      out 1  pulse on each movement tick
//   cnt_canoe       out 4  canoe track position
//   cnt_pass        out 2  column of the carried passenger
//   cat/dog/mouse/canoe_position out 1 each  0 near bank, 1 far bank
//   ones, tens      out 4 each  BCD count of completed crossings
//   done_pulse      out 1  pulse during the single LAND cycle
// ---------------------------------------------------------------------------
module crossing_scheduler
    import crossing_pkg::*;
#(
    parameter int TICK_DIV   = 250,
    parameter int CANOE_LAST = CANOE_LAST_DEFAULT
) (
    input  logic       clk_1kHz,
    input  logic       btn_0_out,
    input  logic       en,
    input  logic       req_cat,
    input  logic       req_dog,
    input  logic       req_mouse,
    input  logic       req_canoe,
    output logic       busy,
    output logic [1:0] grant,
    output logic       req_drop,
    output logic       step_pulse,
    output logic [3:0] cnt_canoe,
    output logic [1:0] cnt_pass,
    output logic       cat_position,
    output logic       dog_position,
    output logic       mouse_position,
    output logic       canoe_position,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       done_pulse
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    state_t           state;
    logic [DIV_W-1:0] tick_div;
    logic             any_req;
    logic [1:0]       winner;
    logic             winner_pos;
    logic             bank_ok;
    logic             safe_ok;
    logic             tick;
    logic [3:0]       cnt_next;
    logic             at_bank;

    assign any_req = req_cat | req_dog | req_mouse | req_canoe;
    assign winner  = priority_winner(req_cat, req_dog, req_mouse);

    // Bank of whoever won arbitration; a canoe-only job compares the canoe
    // with itself, which is why it is always bank-legal.
    always_comb begin
        winner_pos = canoe_position;
        case (winner)
            GRANT_CAT:   winner_pos = cat_position;
            GRANT_DOG:   winner_pos = dog_position;
            GRANT_MOUSE: winner_pos = mouse_position;
            default:     winner_pos = canoe_position;
        endcase
    end

    assign bank_ok = (winner_pos == canoe_position);

`ifdef SAFETY_CHECK_EN
    logic cat_stays;
    logic dog_stays;
    logic mouse_stays;

    // Animals left behind on the bank the canoe departs from; the cat may
    // not be left there with either of the others.
    always_comb begin
        cat_stays   = (cat_position   == canoe_position) && (winner != GRANT_CAT);
        dog_stays   = (dog_position   == canoe_position) && (winner != GRANT_DOG);
        mouse_stays = (mouse_position == canoe_position) && (winner != GRANT_MOUSE);
        safe_ok     = !(cat_stays && (dog_stays || mouse_stays));
    end
`else
    assign safe_ok = 1'b1;
`endif

    // Movement tick is the last divider count while moving. The next
    // canoe position depends on which bank the trip started from.
    assign tick       = (state == MOVE) && (tick_div == DIV_LAST);
    assign step_pulse = tick;
    assign cnt_next   = canoe_position ? (cnt_canoe - 4'd1) : (cnt_canoe + 4'd1);
    assign at_bank    = canoe_position ? (cnt_next == 4'd0)
                                       : (cnt_next == 4'(CANOE_LAST));

    // Scheduler FSM. Requests are only judged while idle; anything arriving
    // during a transit is answered with a drop pulse and otherwise ignored.
    // Positions change only on the edge leaving LAND, so the canoe direction
    // stays fixed for the whole transit.
    always_ff @(posedge clk_1kHz or posedge btn_0_out) begin
        if (btn_0_out) begin
            state          <= IDLE;
            tick_div       <= '0;
            busy           <= 1'b0;
            grant          <= GRANT_CAT;
            req_drop       <= 1'b0;
            done_pulse     <= 1'b0;
            cnt_canoe      <= 4'd0;
            cnt_pass       <= 2'd0;
            cat_position   <= 1'b0;
            dog_position   <= 1'b0;
            mouse_position <= 1'b0;
            canoe_position <= 1'b0;
        end else begin
            req_drop   <= 1'b0;
            done_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && any_req) begin
                        if (bank_ok && safe_ok) begin
                            state    <= MOVE;
                            busy     <= 1'b1;
                            grant    <= winner;
                            tick_div <= '0;
                        end else begin
                            req_drop <= 1'b1;
                        end
                    end
                end
                MOVE: begin
                    if (en && any_req)
                        req_drop <= 1'b1;
                    if (tick) begin
                        tick_div  <= '0;
                        cnt_canoe <= cnt_next;
                        if (grant != GRANT_CANOE)
                            cnt_pass <= cnt_next[3:2];
                        if (at_bank) begin
                            state      <= LAND;
                            done_pulse <= 1'b1;
                        end
                    end else begin
                        tick_div <= tick_div + DIV_W'(1);
                    end
                end
                LAND: begin
                    if (en && any_req)
                        req_drop <= 1'b1;
                    state          <= IDLE;
                    busy           <= 1'b0;
                    canoe_position <= ~canoe_position;
                    case (grant)
                        GRANT_CAT:   cat_position   <= ~cat_position;
                        GRANT_DOG:   dog_position   <= ~dog_position;
                        GRANT_MOUSE: mouse_position <= ~mouse_position;
                        default:     ;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The move count advances on the same edge that leaves LAND.
    bcd_move_counter u_bcd (
        .clk  (clk_1kHz),
        .rst  (btn_0_out),
        .inc  (state == LAND),
        .ones (ones),
        .tens (tens)
    );

endmodule

// File: tb/tb_crossing_scheduler.sv
// ---------------------------------------------------------------------------
// tb_crossing_scheduler
// Self-checking bench for crossing_scheduler with TICK_DIV=4. A small game
// model (bank of each animal, canoe bank, move count) predicts acceptance,
// the timing of every transit and the final positions and BCD count.
// ---------------------------------------------------------------------------
module tb_crossing_scheduler;

    localparam int TD = 4;
    localparam int CL = 15;
    localparam int L  = CL * TD;

    logic       clk_1kHz = 1'b0;
    logic       btn_0_out;
    logic       en;
    logic       req_cat;
    logic       req_dog;
    logic       req_mouse;
    logic       req_canoe;
    logic       busy;
    logic [1:0] grant;
    logic       req_drop;
    logic       step_pulse;
    logic [3:0] cnt_canoe;
    logic [1:0] cnt_pass;
    logic       cat_position;
    logic       dog_position;
    logic       mouse_position;
    logic       canoe_position;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       done_pulse;

    int checks = 0;
    int errors = 0;

    logic       m_pos [0:2];
    logic       m_canoe;
    int         m_moves;
    logic [1:0] m_grant;

    crossing_scheduler #(.TICK_DIV(TD), .CANOE_LAST(CL)) dut (
        .clk_1kHz       (clk_1kHz),
        .btn_0_out      (btn_0_out),
        .en             (en),
        .req_cat        (req_cat),
        .req_dog        (req_dog),
        .req_mouse      (req_mouse),
        .req_canoe      (req_canoe),
        .busy           (busy),
        .grant          (grant),
        .req_drop       (req_drop),
        .step_pulse     (step_pulse),
        .cnt_canoe      (cnt_canoe),
        .cnt_pass       (cnt_pass),
        .cat_position   (cat_position),
        .dog_position   (dog_position),
        .mouse_position (mouse_position),
        .canoe_position (canoe_position),
        .ones           (ones),
        .tens           (tens),
        .done_pulse     (done_pulse)
    );

    // 10 time-unit clock period
    always #5 clk_1kHz = ~clk_1kHz;

    // Hard stop in case something upstream ever blocks.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs,
                               input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk_1kHz);
        #1;
    endtask

    // Present requests for exactly one cycle.
    task automatic applyStimulus(input logic [3:0] reqs, input logic en_v);
        en = en_v;
        {req_canoe, req_mouse, req_dog, req_cat} = reqs;
        nextCycle();
        {req_canoe, req_mouse, req_dog, req_cat} = 4'b0000;
    endtask

    function automatic logic [1:0] modelWinner(input logic [3:0] reqs);
        if (reqs[0]) return 2'd0;
        if (reqs[1]) return 2'd1;
        if (reqs[2]) return 2'd2;
        return 2'd3;
    endfunction

    // A passenger must board from the canoe's bank; with the safety rule
    // the cat may not be left with dog or mouse on the departing bank.
    function automatic logic modelLegal(input logic [1:0] w);
        logic ok;
        ok = (w == 2'd3) || (m_pos[w] == m_canoe);
`ifdef SAFETY_CHECK_EN
        begin
            logic stay [0:2];
            for (int i = 0; i < 3; i++)
                stay[i] = (m_pos[i] == m_canoe) && (int'(w) != i);
            if (stay[0] && (stay[1] || stay[2]))
                ok = 1'b0;
        end
`endif
        return ok;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++)
            m_pos[i] = 1'b0;
        m_canoe = 1'b0;
        m_moves = 0;
        m_grant = 2'd0;
    endtask

    task automatic checkIdle();
        checkOutput("busy_idle", busy, 8'(0));
        checkOutput("done_idle", done_pulse, 8'(0));
        checkOutput("step_idle", step_pulse, 8'(0));
        checkOutput("grant_hold", grant, 8'(m_grant));
        checkOutput("cat_position", cat_position, 8'(m_pos[0]));
        checkOutput("dog_position", dog_position, 8'(m_pos[1]));
        checkOutput("mouse_position", mouse_position, 8'(m_pos[2]));
        checkOutput("canoe_position", canoe_position, 8'(m_canoe));
        checkOutput("ones", ones, 8'(m_moves % 10));
        checkOutput("tens", tens, 8'(m_moves / 10));
        checkOutput("cnt_canoe_idle", cnt_canoe, 8'(m_canoe ? CL : 0));
    endtask

    task automatic checkAllZero(input string tag);
        logic [31:0] packed_out;
        packed_out = {busy, grant, req_drop, step_pulse, cnt_canoe, cnt_pass,
                      cat_position, dog_position, mouse_position, canoe_position,
                      ones, tens, done_pulse, 8'd0};
        checkOutput({tag, "_hi"}, packed_out[31:24], 8'(0));
        checkOutput({tag, "_mid"}, packed_out[23:16], 8'(0));
        checkOutput({tag, "_lo"}, packed_out[15:8], 8'(0));
    endtask

    // Walk one accepted transit. Cycle k=0 is the first busy cycle; the
    // canoe has advanced k/TD steps by cycle k and lands at k=L. A request
    // injected at cycle mid_k must be answered by a drop one cycle later.
    task automatic runTransit(input logic [1:0] w, input int mid_k);
        logic far;
        logic mid_en;
        int   ticks;
        far    = (m_canoe == 1'b0);
        mid_en = 1'b0;
        for (int k = 0; k <= L; k++) begin
            if (k > 0)
                nextCycle();
            if (k == mid_k + 1)
                {req_canoe, req_mouse, req_dog, req_cat} = 4'b0000;
            ticks = k / TD;
            checkOutput("busy_move", busy, 8'(1));
            checkOutput("req_drop_move", req_drop,
                        8'((mid_k >= 0 && k == mid_k + 1) ? mid_en : 1'b0));
            checkOutput("cnt_canoe", cnt_canoe, 8'(far ? ticks : CL - ticks));
            checkOutput("step_pulse", step_pulse,
                        8'((k < L) && (k % TD == TD - 1)));
            checkOutput("done_pulse", done_pulse, 8'(k == L));
            checkOutput("grant_move", grant, 8'(w));
            if (far && w != 2'd3 && k >= TD)
                checkOutput("cnt_pass", cnt_pass, 8'(ticks >> 2));
            if (k == mid_k) begin
                mid_en = 1'($urandom_range(0, 1));
                en = mid_en;
                {req_canoe, req_mouse, req_dog, req_cat} = 4'($urandom_range(1, 15));
            end else begin
                en = 1'($urandom_range(0, 1));
            end
        end
        nextCycle();
        m_canoe = ~m_canoe;
        if (w != 2'd3)
            m_pos[w] = ~m_pos[w];
        if (m_moves < 99)
            m_moves++;
        m_grant = w;
        checkOutput("req_drop_after", req_drop, 8'(0));
        checkIdle();
    endtask

    task automatic doRequest(input logic [3:0] reqs, input logic en_v,
                             input int mid_k);
        logic       active;
        logic       legal;
        logic [1:0] w;
        active = en_v && (reqs != 4'b0000);
        w      = modelWinner(reqs);
        legal  = modelLegal(w);
        applyStimulus(reqs, en_v);
        checkOutput("req_drop", req_drop, 8'(active && !legal));
        checkOutput("busy_start", busy, 8'(active && legal));
        if (active && legal) begin
            runTransit(w, mid_k);
        end else begin
            nextCycle();
            checkOutput("req_drop_clear", req_drop, 8'(0));
            checkIdle();
        end
    endtask

    // Raise reset between clock edges and check it acts without a clock.
    task automatic resetPulse(input string tag);
        #2;
        btn_0_out = 1'b1;
        {req_canoe, req_mouse, req_dog, req_cat} = 4'b0000;
        #1;
        checkAllZero(tag);
        nextCycle();
        btn_0_out = 1'b0;
        modelReset();
    endtask

    initial begin
        btn_0_out = 1'b1;
        en        = 1'b0;
        {req_canoe, req_mouse, req_dog, req_cat} = 4'b0000;
        modelReset();
        repeat (3) nextCycle();
        checkAllZero("reset_hold");
        btn_0_out = 1'b0;
        repeat (6) nextCycle();
        checkIdle();

        $display("[TB] directed sequence");
        doRequest(4'b0001, 1'b0, -1);
        doRequest(4'b0011, 1'b1, -1);
        doRequest(4'b0010, 1'b1, -1);
        doRequest(4'b1000, 1'b1, 20);
        doRequest(4'b0100, 1'b1, -1);

        $display("[TB] random sequence");
        for (int i = 0; i < 30; i++) begin
            doRequest(4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, L - 1)) : -1);
        end

        $display("[TB] reset during transit");
        resetPulse("reset_idle");
        applyStimulus(4'b0001, 1'b1);
        for (int i = 0; i < 200 && cnt_canoe != 4'd7; i++)
            nextCycle();
        checkOutput("reach_cnt7", cnt_canoe, 8'(7));
        resetPulse("reset_mid");
        checkIdle();

        $display("[TB] count saturation");
        for (int i = 0; i < 101; i++)
            doRequest(4'b1000, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
